// File: rtl/fsab_dma_reader_if.sv
// fsab_dma_reader_if: control, FSAB request/return and output stream signals of the DMA reader.
// FSAB field widths default to the standard bus layout unless already defined.
`ifndef FSAB_ADDR_HI
`define FSAB_ADDR_HI 30
`endif
`ifndef FSAB_DATA_HI
`define FSAB_DATA_HI 63
`endif
`ifndef FSAB_MASK_HI
`define FSAB_MASK_HI 7
`endif
`ifndef FSAB_DID_HI
`define FSAB_DID_HI 3
`endif
`ifndef FSAB_LEN_HI
`define FSAB_LEN_HI 3
`endif
`ifndef FSAB_REQ_HI
`define FSAB_REQ_HI 0
`endif
`ifndef FSAB_READ
`define FSAB_READ 0
`endif

interface fsab_dma_reader_if;
  logic                   ctl_start;
  logic [`FSAB_ADDR_HI:0] ctl_base;
  logic [15:0]            ctl_nbursts;
  logic                   ctl_stop;
  logic                   ctl_busy;

  logic                   dma__fsabo_valid;
  logic [`FSAB_REQ_HI:0]  dma__fsabo_mode;
  logic [`FSAB_DID_HI:0]  dma__fsabo_did;
  logic [`FSAB_DID_HI:0]  dma__fsabo_subdid;
  logic [`FSAB_ADDR_HI:0] dma__fsabo_addr;
  logic [`FSAB_LEN_HI:0]  dma__fsabo_len;
  logic [`FSAB_DATA_HI:0] dma__fsabo_data;
  logic [`FSAB_MASK_HI:0] dma__fsabo_mask;
  logic                   dma__fsabo_credit;

  logic                   fsabi_valid;
  logic [`FSAB_DID_HI:0]  fsabi_did;
  logic [`FSAB_DID_HI:0]  fsabi_subdid;
  logic [`FSAB_DATA_HI:0] fsabi_data;

  logic                   strm_valid;
  logic [`FSAB_DATA_HI:0] strm_data;
  logic                   strm_ready;

  modport master (
    input  ctl_start, ctl_base, ctl_nbursts, ctl_stop,
    output ctl_busy,
    output dma__fsabo_valid, dma__fsabo_mode, dma__fsabo_did, dma__fsabo_subdid,
    output dma__fsabo_addr, dma__fsabo_len, dma__fsabo_data, dma__fsabo_mask,
    input  dma__fsabo_credit,
    input  fsabi_valid, fsabi_did, fsabi_subdid, fsabi_data,
    output strm_valid, strm_data,
    input  strm_ready
  );

  modport slave (
    output ctl_start, ctl_base, ctl_nbursts, ctl_stop,
    input  ctl_busy,
    input  dma__fsabo_valid, dma__fsabo_mode, dma__fsabo_did, dma__fsabo_subdid,
    input  dma__fsabo_addr, dma__fsabo_len, dma__fsabo_data, dma__fsabo_mask,
    output dma__fsabo_credit,
    output fsabi_valid, fsabi_did, fsabi_subdid, fsabi_data,
    input  strm_valid, strm_data,
    output strm_ready
  );
endinterface

// File: rtl/fsab_dma_reader.sv
// fsab_dma_reader: read-only FSAB master fetching a linear DRAM region in bursts as a word stream.
// Define FSAB_DMA_LOOP_EN to restart from the latched base after each pass until ctl_stop.
`ifndef FSAB_ADDR_HI
`define FSAB_ADDR_HI 30
`endif
`ifndef FSAB_DATA_HI
`define FSAB_DATA_HI 63
`endif
`ifndef FSAB_MASK_HI
`define FSAB_MASK_HI 7
`endif
`ifndef FSAB_DID_HI
`define FSAB_DID_HI 3
`endif
`ifndef FSAB_LEN_HI
`define FSAB_LEN_HI 3
`endif
`ifndef FSAB_REQ_HI
`define FSAB_REQ_HI 0
`endif
`ifndef FSAB_READ
`define FSAB_READ 0
`endif

module fsab_dma_reader #(
  parameter int unsigned DMA_DID      = 3,
  parameter int unsigned BURST_LEN    = 8,
  parameter int unsigned FIFO_DEPTH   = 32,
  parameter int unsigned FSAB_CREDITS = 4
) (
  input logic               clk,
  input logic               rst,
  fsab_dma_reader_if.master bus
);

  localparam int unsigned ADDR_W = `FSAB_ADDR_HI + 1;
  localparam int unsigned DATA_W = `FSAB_DATA_HI + 1;
  localparam int unsigned DID_W  = `FSAB_DID_HI + 1;
  localparam int unsigned LEN_W  = `FSAB_LEN_HI + 1;
  localparam int unsigned REQ_W  = `FSAB_REQ_HI + 1;
  localparam int unsigned MASK_W = `FSAB_MASK_HI + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 2;
  localparam int unsigned CRD_W  = $clog2(FSAB_CREDITS + 1);
  localparam int unsigned STRIDE = BURST_LEN * DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  cur_addr;
  logic [15:0]        bursts_left;
  logic [15:0]        burst_idx;
  logic [CRD_W-1:0]   credits;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   fifo_count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
`ifdef FSAB_DMA_LOOP_EN
  logic [ADDR_W-1:0]  base_q;
  logic [15:0]        nbursts_q;
`endif

  logic room_c, fire_c, last_c, beat_c, pop_c, start_c, unused_c;

  // Space is reserved for whole bursts at issue time, so returns can never overflow the FIFO.
  assign room_c  = (fifo_count + outstanding + CNT_W'(BURST_LEN)) <= CNT_W'(FIFO_DEPTH);
  assign fire_c  = (state == S_ISSUE) && (credits != '0) && (bursts_left != '0) && room_c && !bus.ctl_stop;
  assign last_c  = fire_c && (bursts_left == 16'd1);
  assign beat_c  = bus.fsabi_valid && (bus.fsabi_did == DID_W'(DMA_DID)) && (state != S_IDLE);
  assign pop_c   = (fifo_count != '0) && (!bus.strm_valid || bus.strm_ready);
  assign start_c = (state == S_IDLE) && bus.ctl_start && !bus.ctl_busy && (bus.ctl_nbursts != 16'd0);
  assign unused_c = ^bus.fsabi_subdid;

  assign bus.dma__fsabo_mode = REQ_W'(`FSAB_READ);
  assign bus.dma__fsabo_did  = DID_W'(DMA_DID);
  assign bus.dma__fsabo_len  = LEN_W'(BURST_LEN);
  assign bus.dma__fsabo_data = '0;
  assign bus.dma__fsabo_mask = MASK_W'(0);

  // Return buffer storage; no reset needed, validity is tracked by fifo_count.
  always_ff @(posedge clk) begin
    if (beat_c) mem[wr_ptr] <= bus.fsabi_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= S_IDLE;
      cur_addr              <= '0;
      bursts_left           <= '0;
      burst_idx             <= '0;
      credits               <= CRD_W'(FSAB_CREDITS);
      outstanding           <= '0;
      fifo_count            <= '0;
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      bus.ctl_busy          <= 1'b0;
      bus.dma__fsabo_valid  <= 1'b0;
      bus.dma__fsabo_subdid <= '0;
      bus.dma__fsabo_addr   <= '0;
      bus.strm_valid        <= 1'b0;
      bus.strm_data         <= '0;
`ifdef FSAB_DMA_LOOP_EN
      base_q                <= '0;
      nbursts_q             <= '0;
`endif
    end else begin
      bus.dma__fsabo_valid <= fire_c;
      bus.ctl_busy         <= start_c || (state != S_IDLE);

      if (fire_c) begin
        bus.dma__fsabo_addr   <= cur_addr;
        bus.dma__fsabo_subdid <= burst_idx[DID_W-1:0];
        cur_addr              <= cur_addr + ADDR_W'(STRIDE);
        bursts_left           <= bursts_left - 16'd1;
        burst_idx             <= burst_idx + 16'd1;
      end

      // A credit return coinciding with a request leaves the count unchanged.
      case ({fire_c, bus.dma__fsabo_credit})
        2'b10:   credits <= credits - CRD_W'(1);
        2'b01:   if (credits != CRD_W'(FSAB_CREDITS)) credits <= credits + CRD_W'(1);
        default: ;
      endcase

      outstanding <= outstanding + (fire_c ? CNT_W'(BURST_LEN) : CNT_W'(0))
                                 - (beat_c ? CNT_W'(1) : CNT_W'(0));
      fifo_count  <= fifo_count + CNT_W'(beat_c) - CNT_W'(pop_c);
      if (beat_c) wr_ptr <= wr_ptr + PTR_W'(1);

      // Registered output stage: refill whenever empty or being consumed.
      if (pop_c) begin
        bus.strm_data  <= mem[rd_ptr];
        bus.strm_valid <= 1'b1;
        rd_ptr         <= rd_ptr + PTR_W'(1);
      end else if (bus.strm_ready) begin
        bus.strm_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start_c) begin
            cur_addr    <= bus.ctl_base;
            bursts_left <= bus.ctl_nbursts;
            burst_idx   <= '0;
`ifdef FSAB_DMA_LOOP_EN
            base_q      <= bus.ctl_base;
            nbursts_q   <= bus.ctl_nbursts;
`endif
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.ctl_stop) begin
            state <= S_DRAIN;
          end else if (last_c) begin
`ifdef FSAB_DMA_LOOP_EN
            cur_addr    <= base_q;
            bursts_left <= nbursts_q;
`else
            state       <= S_DRAIN;
`endif
          end else if (bursts_left == 16'd0) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((outstanding == '0) && (fifo_count == '0) && !bus.strm_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsab_dma_reader.sv
// tb_fsab_dma_reader: directed vector table plus hand sequences for credits, backpressure, stop and reset.
module tb_fsab_dma_reader;

  localparam int unsigned ADDR_W = 31;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRIDE = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fsab_dma_reader_if bus();

  fsab_dma_reader #(.DMA_DID(3), .BURST_LEN(8), .FIFO_DEPTH(32), .FSAB_CREDITS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { logic [DATA_W-1:0] data; int due; } beat_t;
  logic [ADDR_W-1:0] req_q[$];
  logic [3:0]        sub_q[$];
  logic [DATA_W-1:0] word_q[$];
  beat_t             beat_q[$];
  bit auto_credit, mem_en, foreign_en, ready_toggle;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [15:0]       nb;
    bit                toggle;
    bit                foreign;
    int                exp_reqs;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [DATA_W-1:0] word_of(logic [ADDR_W-1:0] a, int b);
    return {1'b0, a, 24'h5A0000, 8'(b)};
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Memory/consumer model: records requests and stream words, returns 8 beats per request after 5 cycles.
  initial begin
    bus.fsabi_valid = 1'b0; bus.fsabi_did = '0; bus.fsabi_subdid = '0; bus.fsabi_data = '0;
    bus.dma__fsabo_credit = 1'b0; bus.strm_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (ready_toggle) bus.strm_ready = (cyc % 2 == 0);
      if (auto_credit) bus.dma__fsabo_credit = bus.dma__fsabo_valid;
      if (bus.dma__fsabo_valid === 1'b1) begin
        req_q.push_back(bus.dma__fsabo_addr);
        sub_q.push_back(bus.dma__fsabo_subdid);
        if (mem_en) for (int b = 0; b < 8; b++) beat_q.push_back('{word_of(bus.dma__fsabo_addr, b), cyc + 5});
      end
      if (bus.strm_valid === 1'b1 && bus.strm_ready === 1'b1) word_q.push_back(bus.strm_data);
      if (foreign_en && (cyc % 3 == 0)) begin
        bus.fsabi_valid = 1'b1; bus.fsabi_did = 4'd5; bus.fsabi_subdid = 4'd1; bus.fsabi_data = 64'hDEAD_BEEF_0BAD_F00D;
      end else if (beat_q.size() > 0 && beat_q[0].due <= cyc) begin
        bus.fsabi_valid = 1'b1; bus.fsabi_did = 4'd3; bus.fsabi_subdid = 4'd0; bus.fsabi_data = beat_q[0].data;
        void'(beat_q.pop_front());
      end else begin
        bus.fsabi_valid = 1'b0;
      end
    end
  end

  task automatic clear_queues();
    req_q.delete(); sub_q.delete(); word_q.delete(); beat_q.delete();
  endtask

  task automatic do_reset();
    auto_credit = 0; mem_en = 0; foreign_en = 0; ready_toggle = 0;
    bus.ctl_start = 1'b0; bus.ctl_base = '0; bus.ctl_nbursts = '0; bus.ctl_stop = 1'b0;
    bus.dma__fsabo_credit = 1'b0; bus.strm_ready = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    clear_queues();
  endtask

  task automatic start_xfer(logic [ADDR_W-1:0] base, logic [15:0] nb);
    bus.ctl_base = base; bus.ctl_nbursts = nb; bus.ctl_start = 1'b1;
    step(1);
    bus.ctl_start = 1'b0;
  endtask

  task automatic wait_not_busy(string name, int budget);
    int n = 0;
    while (bus.ctl_busy === 1'b1 && n < budget) begin step(1); n++; end
    check({name, " busy fall within budget"}, 64'(n < budget), 64'd1);
  endtask

  task automatic check_stream(string name, logic [ADDR_W-1:0] base, int nreq);
    int bad;
    logic [ADDR_W-1:0] a;
    check({name, " request count"}, 64'(req_q.size()), 64'(nreq));
    bad = 0;
    for (int k = 0; k < nreq && k < req_q.size(); k++) begin
      a = base + ADDR_W'(k * STRIDE);
      if (req_q[k] !== a || sub_q[k] !== 4'(k)) bad++;
    end
    check({name, " request addr/tag errors"}, 64'(bad), 64'd0);
    check({name, " word count"}, 64'(word_q.size()), 64'(nreq * 8));
    bad = 0;
    for (int i = 0; i < word_q.size() && i < nreq * 8; i++) begin
      a = base + ADDR_W'((i / 8) * STRIDE);
      if (word_q[i] !== word_of(a, i % 8)) bad++;
    end
    check({name, " word order errors"}, 64'(bad), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{31'h0000_1000, 16'd1, 1'b0, 1'b0, 1};
    vecs[1] = '{31'h0000_2000, 16'd3, 1'b1, 1'b1, 3};
    vecs[2] = '{31'h7FFF_FFC0, 16'd2, 1'b0, 1'b0, 2};
    vecs[3] = '{31'h0000_3000, 16'd0, 1'b0, 1'b0, 0};
    vecs[4] = '{31'h0000_0040, 16'd8, 1'b1, 1'b1, 8};

    // Reset values and first-request latency.
    do_reset();
    check("rst busy",   64'(bus.ctl_busy), 64'd0);
    check("rst valid",  64'(bus.dma__fsabo_valid), 64'd0);
    check("rst strm",   64'(bus.strm_valid), 64'd0);
    check("rst addr",   64'(bus.dma__fsabo_addr), 64'd0);
    check("rst subdid", 64'(bus.dma__fsabo_subdid), 64'd0);
    check("rst mode",   64'(bus.dma__fsabo_mode), 64'd0);
    check("rst did",    64'(bus.dma__fsabo_did), 64'd3);
    check("rst len",    64'(bus.dma__fsabo_len), 64'd8);
    check("rst data",   64'(bus.dma__fsabo_data), 64'd0);
    check("rst mask",   64'(bus.dma__fsabo_mask), 64'd0);
    auto_credit = 1; mem_en = 1; bus.strm_ready = 1'b1;
    start_xfer(31'h1000, 16'd1);
    check("cycle1 busy",  64'(bus.ctl_busy), 64'd1);
    check("cycle1 valid", 64'(bus.dma__fsabo_valid), 64'd0);
    step(1);
    check("cycle2 valid", 64'(bus.dma__fsabo_valid), 64'd1);
    check("cycle2 addr",  64'(bus.dma__fsabo_addr), 64'h1000);
    step(1);
    check("cycle3 single request", 64'(bus.dma__fsabo_valid), 64'd0);
    wait_not_busy("timing", 200);

    // Table of whole transfers.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      auto_credit = 1; mem_en = 1;
      foreign_en = vecs[v].foreign;
      ready_toggle = vecs[v].toggle;
      if (!vecs[v].toggle) bus.strm_ready = 1'b1;
      start_xfer(vecs[v].base, vecs[v].nb);
      if (vecs[v].nb == 16'd0) begin
        check($sformatf("vec%0d busy stays low", v), 64'(bus.ctl_busy), 64'd0);
        step(20);
      end else begin
        wait_not_busy($sformatf("vec%0d", v), 600);
      end
      check_stream($sformatf("vec%0d", v), vecs[v].base, vecs[v].exp_reqs);
    end

    // Credit starvation then one request per returned credit.
    do_reset();
    mem_en = 1; bus.strm_ready = 1'b1;
    start_xfer(31'h0001_0000, 16'd10);
    step(40);
    check("credit starve requests", 64'(req_q.size()), 64'd4);
    for (int i = 0; i < 6; i++) begin
      bus.dma__fsabo_credit = 1'b1;
      step(1);
      bus.dma__fsabo_credit = 1'b0;
      step(11);
      check($sformatf("credit release %0d", i), 64'(req_q.size()), 64'(5 + i));
    end
    wait_not_busy("credit", 300);
    check_stream("credit", 31'h0001_0000, 10);

    // Backpressure: only FIFO_DEPTH words may be in flight while the consumer stalls.
    do_reset();
    auto_credit = 1; mem_en = 1;
    start_xfer(31'h0002_0000, 16'd8);
    step(60);
    check("bp requests capped", 64'(req_q.size()), 64'd4);
    check("bp strm_valid", 64'(bus.strm_valid), 64'd1);
    check("bp head word", bus.strm_data, word_of(31'h0002_0000, 0));
    step(3);
    check("bp head held", bus.strm_data, word_of(31'h0002_0000, 0));
    bus.strm_ready = 1'b1;
    wait_not_busy("bp", 400);
    check_stream("bp", 31'h0002_0000, 8);

    // ctl_stop after two requests: in-flight data still delivered.
    do_reset();
    auto_credit = 1; mem_en = 1; bus.strm_ready = 1'b1;
    start_xfer(31'h0000_8000, 16'd6);
    step(2);
    bus.ctl_stop = 1'b1;
    wait_not_busy("stop", 200);
    check("stop idle strm", 64'(bus.strm_valid), 64'd0);
    bus.ctl_stop = 1'b0;
    check_stream("stop", 31'h0000_8000, 2);

    // Asynchronous reset in the middle of issue.
    do_reset();
    bus.strm_ready = 1'b1;
    start_xfer(31'h0003_0000, 16'd10);
    step(3);
    check("pre-reset busy", 64'(bus.ctl_busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst valid",  64'(bus.dma__fsabo_valid), 64'd0);
    check("async rst busy",   64'(bus.ctl_busy), 64'd0);
    check("async rst strm",   64'(bus.strm_valid), 64'd0);
    check("async rst addr",   64'(bus.dma__fsabo_addr), 64'd0);
    step(2);
    rst = 1'b0;
    clear_queues();
    beat_q.push_back('{word_of(31'h0003_0000, 0), 0});
    step(10);
    check("late beat dropped words", 64'(word_q.size()), 64'd0);
    check("late beat strm_valid", 64'(bus.strm_valid), 64'd0);
    mem_en = 1;
    start_xfer(31'h0003_0000, 16'd10);
    step(40);
    check("credits restored", 64'(req_q.size()), 64'd4);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsab_dma_reader.md
# fsab_dma_reader

Read-only FSAB bus master that fetches a linear region of DRAM in fixed-length bursts and presents it as a ready/valid word stream. It sits upstream of the FSAB arbiter as an additional request port, alongside the preload, icache and dcache ports. It consumes the shared `fsabi_*` read-return bus from the memory controller and filters it by its own DID. Typical consumers are a framebuffer scanout or an audio sink.

## Interface
Parameters:
- `DMA_DID`, 3: FSAB device ID placed on requests; only returns carrying this DID are accepted.
- `BURST_LEN`, 8: words per read request, driven on `fsabo_len`.
- `FIFO_DEPTH`, 32: return-buffer depth in words; power of two, ≥ 2×`BURST_LEN`.
- `FSAB_CREDITS`, 4: initial request credits.

Ports:
- `clk` in 1: single clock; the block, the arbiter port and `fsabi_*` all run on this clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ctl_start` in 1: one-cycle pulse that starts a transfer; ignored while `ctl_busy`.
- `ctl_base` in FSAB_ADDR_HI+1: start byte address, burst-aligned; sampled on `ctl_start`.
- `ctl_nbursts` in 16: number of bursts; sampled on `ctl_start`; 0 means no transfer.
- `ctl_stop` in 1: level; aborts request issue.
- `ctl_busy` out 1: high from the cycle after an accepted start until the FIFO is drained and no returns are outstanding.
- `dma__fsabo_valid` out 1: request valid, one cycle per request.
- `dma__fsabo_mode` out FSAB_REQ_HI+1: always `FSAB_READ`.
- `dma__fsabo_did` out FSAB_DID_HI+1: `DMA_DID`.
- `dma__fsabo_subdid` out FSAB_DID_HI+1: burst tag, low bits of the burst index.
- `dma__fsabo_addr` out FSAB_ADDR_HI+1: burst address.
- `dma__fsabo_len` out FSAB_LEN_HI+1: `BURST_LEN`.
- `dma__fsabo_data` out FSAB_DATA_HI+1: 0.
- `dma__fsabo_mask` out FSAB_MASK_HI+1: 0.
- `dma__fsabo_credit` in 1: pulse that returns one request credit.
- `fsabi_valid` in 1: return beat valid.
- `fsabi_did` in FSAB_DID_HI+1: return DID.
- `fsabi_subdid` in FSAB_DID_HI+1: return tag; informational only.
- `fsabi_data` in FSAB_DATA_HI+1: return data word.
- `strm_valid` out 1: output word valid.
- `strm_data` out FSAB_DATA_HI+1: output word.
- `strm_ready` in 1: consumer accepts the word on `strm_valid & strm_ready`.

## Operation
- State machine states: IDLE, ISSUE, DRAIN.
- IDLE:
  - On `ctl_start`, latch the address into `cur_addr` and the burst count into `bursts_left`.
  - Go to ISSUE, or stay in IDLE if `ctl_nbursts`==0.
- ISSUE: a request fires when all of the following hold:
  - `credits` > 0;
  - `bursts_left` > 0;
  - `fifo_free - outstanding_words` ≥ `BURST_LEN`;
  - `ctl_stop` is low.
- On each request fire:
  - `cur_addr` += `BURST_LEN`×(FSAB_DATA_HI+1)/8;
  - `bursts_left` -= 1;
  - `credits` -= 1;
  - `outstanding_words` += `BURST_LEN`.
- ISSUE → DRAIN when `bursts_left` reaches 0 or `ctl_stop` is high.
- DRAIN → IDLE when `outstanding_words`==0 and the FIFO is empty.
- Credit counter:
  - `dma__fsabo_credit` increments `credits`.
  - A credit return and a request fire in the same cycle leave `credits` unchanged.
  - `credits` never exceeds `FSAB_CREDITS`.
- Returns:
  - A beat with `fsabi_valid` and `fsabi_did`==`DMA_DID` is written to the FIFO and decrements `outstanding_words`.
  - Other DIDs are ignored.
  - Matching beats arriving in IDLE (stale traffic after a reset) are dropped.
- The FIFO never overflows, because space is reserved at issue time. A write and a read in the same cycle are both honoured, including at full and at empty.
- `ctl_stop` does not cancel in-flight bursts. Their data is still delivered to the stream.
- Reset: all state is cleared; FSM goes to IDLE; `credits` = `FSAB_CREDITS`.
- Reset values of outputs: `ctl_busy` 0, `dma__fsabo_valid` 0, `strm_valid` 0. All other outputs are 0 except the constant fields (mode, did, len).

## Timing
- Request outputs are registered. `dma__fsabo_valid` first asserts 2 cycles after the `ctl_start` pulse (cycle 0 start, cycle 1 ISSUE, cycle 2 valid).
- At most one request per cycle. Back-to-back requests are allowed while credits and space last.
- FIFO output is registered. A return beat in cycle N appears on `strm_valid` no earlier than N+1.
- `strm_data` is held stable while `strm_valid & ~strm_ready`.
- `ctl_busy` falls the cycle after the FSM enters IDLE.
- The address counter wraps modulo 2^(FSAB_ADDR_HI+1) without error.

## Configuration
- `FSAB_DMA_LOOP_EN`:
  - When defined: when `bursts_left` reaches 0 in ISSUE, `cur_addr` reloads to the latched base and `bursts_left` to the latched count. Streaming continues until `ctl_stop`, which leads to DRAIN.
  - When undefined: a single pass, then DRAIN and IDLE.

## Test plan
- Single burst: base 0x1000, nbursts 1, `strm_ready`=1, memory returns 8 words after 5 cycles → exactly one request with addr 0x1000 and len 8; 8 stream words in order; `ctl_busy` falls afterwards.
- Credit starvation: `FSAB_CREDITS`=4, nbursts 10, no credit returns → exactly 4 requests. Each credit pulse then releases one more request; 10 requests total with consecutive addresses.
- Backpressure: `strm_ready`=0, nbursts 8 → at most 32 words are requested or outstanding, no FIFO overflow. Releasing `strm_ready` drains all 64 words in order.
- Foreign DID: interleave returns with DID ≠ `DMA_DID` → none appear on the stream and `outstanding_words` is unchanged by them.
- `ctl_stop` after 2 of 6 requests → no further requests; the 16 in-flight words are delivered; return to IDLE.
- Async reset asserted mid-ISSUE → outputs go to their reset values immediately. A late matching return is dropped, and `credits` is restored to 4.
